instruction_fetch_unit: RTL and testbench

- Instruction fetch stage of the MIPS pipeline: holds the program counter and drives the byte address into the combinational instruction memory.
- Captures the returned instruction word into the IF/ID pipeline register.
- Handles decode-stage stall and branch/jump redirect.
- Flags a sticky fetch fault on misaligned or out-of-range PCs.

---
 rtl/instruction_fetch_unit.sv | 114 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// MIPS instruction fetch stage: PC register, IF/ID capture, stall/redirect, sticky fault.
// Build option: define BRANCH_DELAY_SLOT_EN to keep the delay-slot word on a taken redirect.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic        Fault,
    output logic [31:0] FetchCount
);

    typedef enum logic {
        RUN,
        FAULT
    } state_e;

    // Checks run in 33 bits so PC+4 near 2^32 cannot wrap into the legal range.
    localparam logic [32:0] LAST_ADDR = 33'(4 * IMEM_DEPTH - 4);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pcp4_q;
    logic        valid_q;
    logic        fault_q;
    logic [31:0] count_q;

    logic [32:0] pc_plus4_d;
    logic        seq_bad_d;
    logic        tgt_bad_d;

    always_comb begin
        pc_plus4_d = {1'b0, pc_q} + 33'd4;
        seq_bad_d  = pc_plus4_d > LAST_ADDR;
        tgt_bad_d  = (RedirectTarget[1:0] != 2'b00) ||
                     ({1'b0, RedirectTarget} > LAST_ADDR);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pcp4_q  <= 32'h0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            case (state_q)
                RUN: begin
                    if (Stall) begin
                        state_q <= RUN;
                    end else if (Redirect) begin
                        if (tgt_bad_d) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                            valid_q <= 1'b0;
                        end else begin
                            pc_q <= RedirectTarget;
`ifdef BRANCH_DELAY_SLOT_EN
                            instr_q <= Instruction;
                            pcp4_q  <= pc_plus4_d[31:0];
                            valid_q <= 1'b1;
                            count_q <= count_q + 32'd1;
`else
                            instr_q <= 32'h0;
                            valid_q <= 1'b0;
`endif
                        end
                    end else begin
                        instr_q <= Instruction;
                        pcp4_q  <= pc_plus4_d[31:0];
                        valid_q <= 1'b1;
                        count_q <= count_q + 32'd1;
                        // Last word is still delivered; PC parks on it.
                        if (seq_bad_d) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            pc_q <= pc_plus4_d[31:0];
                        end
                    end
                end
                FAULT: begin
                    state_q <= FAULT;
                    fault_q <= 1'b1;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= FAULT;
                    fault_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign Address          = pc_q;
    assign IFID_Instruction = instr_q;
    assign IFID_PCPlus4     = pcp4_q;
    assign IFID_Valid       = valid_q;
    assign Fault            = fault_q;
    assign FetchCount       = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a zero-latency word memory.
// Expectations follow BRANCH_DELAY_SLOT_EN when the bench is built with it.
module tb_instruction_fetch_unit;

    logic        Clk;
    logic        Rst;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        Fault;
    logic [31:0] FetchCount;

    logic [31:0] mem [1024];
    int          npass;
    int          ntotal;
    logic [31:0] ec;

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_DEPTH(1024)
    ) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Stall           (Stall),
        .Redirect        (Redirect),
        .RedirectTarget  (RedirectTarget),
        .Address         (Address),
        .Instruction     (Instruction),
        .IFID_Instruction(IFID_Instruction),
        .IFID_PCPlus4    (IFID_PCPlus4),
        .IFID_Valid      (IFID_Valid),
        .Fault           (Fault),
        .FetchCount      (FetchCount)
    );

    assign Instruction = (Address < 32'h1000) ? mem[Address[11:2]] : 32'h0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [31:0] a,
                           input logic [31:0] ins, input logic [31:0] p4,
                           input logic v, input logic f, input logic [31:0] c);
        chk({tag, ".addr"}, Address, a);
        chk({tag, ".instr"}, IFID_Instruction, ins);
        chk({tag, ".pcp4"}, IFID_PCPlus4, p4);
        chk({tag, ".valid"}, {31'h0, IFID_Valid}, {31'h0, v});
        chk({tag, ".fault"}, {31'h0, Fault}, {31'h0, f});
        chk({tag, ".count"}, FetchCount, c);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        npass = 0;
        ntotal = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h2008_0001 + 32'(i);
        Rst = 1'b1;
        Stall = 1'b0;
        Redirect = 1'b0;
        RedirectTarget = 32'h0;

        #3;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        #9 Rst = 1'b0;

        step();
        chk_all("seq0", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 1'b0, 32'd1);
        step();
        chk_all("seq1", 32'h8, 32'h2008_0002, 32'h8, 1'b1, 1'b0, 32'd2);

        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("stall", 32'h8, 32'h2008_0002, 32'h8, 1'b1, 1'b0, 32'd2);
        end
        Stall = 1'b0;
        step();
        chk_all("unstall", 32'hC, 32'h2008_0003, 32'hC, 1'b1, 1'b0, 32'd3);
        step();
        chk_all("seq3", 32'h10, 32'h2008_0004, 32'h10, 1'b1, 1'b0, 32'd4);

        Redirect = 1'b1;
        RedirectTarget = 32'h40;
        step();
`ifdef BRANCH_DELAY_SLOT_EN
        ec = 32'd5;
        chk_all("redir", 32'h40, 32'h2008_0005, 32'h14, 1'b1, 1'b0, ec);
`else
        ec = 32'd4;
        chk("redir.addr", Address, 32'h40);
        chk("redir.valid", {31'h0, IFID_Valid}, 32'h0);
        chk("redir.instr", IFID_Instruction, 32'h0);
        chk("redir.count", FetchCount, ec);
`endif
        Redirect = 1'b0;
        step();
        ec = ec + 32'd1;
        chk_all("post", 32'h44, 32'h2008_0011, 32'h44, 1'b1, 1'b0, ec);

        Redirect = 1'b1;
        RedirectTarget = 32'h80;
        Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_all("rstall", 32'h44, 32'h2008_0011, 32'h44, 1'b1, 1'b0, ec);
        end
        Stall = 1'b0;
        step();
`ifdef BRANCH_DELAY_SLOT_EN
        ec = ec + 32'd1;
        chk_all("rdrop", 32'h80, 32'h2008_0012, 32'h48, 1'b1, 1'b0, ec);
`else
        chk("rdrop.addr", Address, 32'h80);
        chk("rdrop.valid", {31'h0, IFID_Valid}, 32'h0);
        chk("rdrop.count", FetchCount, ec);
`endif

        RedirectTarget = 32'h42;
        step();
        chk("mis.fault", {31'h0, Fault}, 32'h1);
        chk("mis.valid", {31'h0, IFID_Valid}, 32'h0);
        chk("mis.addr", Address, 32'h80);
        chk("mis.count", FetchCount, ec);
        RedirectTarget = 32'h100;
        Stall = 1'b1;
        step();
        chk("sticky.fault", {31'h0, Fault}, 32'h1);
        chk("sticky.addr", Address, 32'h80);
        Stall = 1'b0;
        step();
        chk("sticky2.fault", {31'h0, Fault}, 32'h1);
        chk("sticky2.addr", Address, 32'h80);
        Redirect = 1'b0;

        #2 Rst = 1'b1;
        #1;
        chk_all("rst1", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1 Rst = 1'b0;

        step();
        chk_all("r1seq", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 1'b0, 32'd1);
        Redirect = 1'b1;
        RedirectTarget = 32'h1000;
        step();
        chk("oor.fault", {31'h0, Fault}, 32'h1);
        chk("oor.valid", {31'h0, IFID_Valid}, 32'h0);
        chk("oor.addr", Address, 32'h4);
        chk("oor.count", FetchCount, 32'd1);
        Redirect = 1'b0;
        #2 Rst = 1'b1;
        #1;
        chk_all("rst2", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1 Rst = 1'b0;

        Redirect = 1'b1;
        RedirectTarget = 32'hFF4;
        step();
`ifdef BRANCH_DELAY_SLOT_EN
        ec = 32'd1;
`else
        ec = 32'd0;
`endif
        chk("hi.addr", Address, 32'hFF4);
        chk("hi.fault", {31'h0, Fault}, 32'h0);
        chk("hi.count", FetchCount, ec);
        Redirect = 1'b0;
        step();
        ec = ec + 32'd1;
        chk_all("hi1", 32'hFF8, 32'h2008_03FE, 32'hFF8, 1'b1, 1'b0, ec);
        step();
        ec = ec + 32'd1;
        chk_all("hi2", 32'hFFC, 32'h2008_03FF, 32'hFFC, 1'b1, 1'b0, ec);
        step();
        ec = ec + 32'd1;
        chk_all("last", 32'hFFC, 32'h2008_0400, 32'h1000, 1'b1, 1'b1, ec);
        step();
        chk_all("parked", 32'hFFC, 32'h2008_0400, 32'h1000, 1'b0, 1'b1, ec);

        #2 Rst = 1'b1;
        #1;
        chk_all("rst3", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1 Rst = 1'b0;
        step();
        chk_all("rst3seq", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 1'b0, 32'd1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
